gpsdc_trip_acc: RTL

//   Downstream consumer of the GPS distance core. Collects each segment distance D (one pulse per

---
 rtl/gpsdc_trip_acc.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/gpsdc_trip_acc.sv
// gpsdc_trip_acc: per-trip accumulator behind the GPS distance core.
// Segment distances are queued in a small FIFO and folded into the running
// trip totals. A trip_end request closes the trip and publishes a result
// record that is held until the host takes it with out_valid && out_ready.
// Optional feature macro: TRIP_AVG_EN adds a serial restoring divider that
// produces trip_avg = floor(trip_sum / seg_cnt). Without it trip_avg is 0.
module gpsdc_trip_acc #(
    parameter int D_W        = 40,
    parameter int SUM_W      = 48,
    parameter int CNT_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d_valid,
    input  logic [D_W-1:0]   d_in,
    input  logic             trip_end,
    input  logic [D_W-1:0]   thr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] trip_sum,
    output logic [CNT_W-1:0] seg_cnt,
    output logic [CNT_W-1:0] rej_cnt,
    output logic [D_W-1:0]   seg_max,
    output logic [D_W-1:0]   trip_avg,
    output logic             ovf,
    output logic             busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

`ifdef TRIP_AVG_EN
    localparam int DCW = $clog2(SUM_W);
    typedef enum logic [1:0] {ACC, DIV, REPORT} state_t;
`else
    typedef enum logic [1:0] {ACC, REPORT} state_t;
`endif

    // Saturating add of one segment into the trip sum.
    function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a,
                                                 input logic [D_W-1:0]   b);
        logic [SUM_W:0] t;
        t = {1'b0, a} + (SUM_W+1)'(b);
        return t[SUM_W] ? {SUM_W{1'b1}} : t[SUM_W-1:0];
    endfunction

    // Saturating increment for the segment / reject counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

`ifdef TRIP_AVG_EN
    // Clamp the full-width quotient into the D_W-bit average.
    function automatic logic [D_W-1:0] sat_avg(input logic [SUM_W-1:0] q);
        return (|(q >> D_W)) ? {D_W{1'b1}} : q[D_W-1:0];
    endfunction
`endif

    logic [D_W-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic [CW-1:0]    end_left;
    logic             end_pend;
    state_t           state;

    logic             empty;
    logic             full;
    logic             end_done;
    logic             pop;
    logic             push;
    logic             drop;
    logic             end_accept;
    logic [D_W-1:0]   head;
    logic             head_rej;

    logic [SUM_W-1:0] acc_sum;
    logic [CNT_W-1:0] acc_cnt;
    logic [CNT_W-1:0] acc_rej;
    logic [D_W-1:0]   acc_max;

    // Entries still queued when end_left reaches zero belong to the next
    // trip, so popping stops on the cycle that closes the trip.
    assign empty      = (count == '0);
    assign full       = (count == CW'(FIFO_DEPTH));
    assign end_done   = (state == ACC) && end_pend && (end_left == '0);
    assign pop        = (state == ACC) && !empty && !end_done;
    assign push       = d_valid && (!full || pop);
    assign drop       = d_valid && full && !pop;
    assign end_accept = trip_end && (state == ACC) && !end_pend;
    assign count_nxt  = count + CW'(push) - CW'(pop);
    assign head       = mem[rd_ptr];
    assign head_rej   = (thr != '0) && (head > thr);
    assign busy       = (state != ACC) || !empty;

    // Sample storage; data only, no reset needed.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= d_in;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
        end
    end

`ifdef TRIP_AVG_EN
    logic [SUM_W-1:0] div_quot;
    logic [SUM_W-1:0] div_quot_nxt;
    logic [CNT_W-1:0] div_rem;
    logic [CNT_W-1:0] div_rem_nxt;
    logic [CNT_W:0]   div_trial;
    logic             div_ge;
    logic [DCW-1:0]   div_cnt;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    assign div_trial    = {div_rem, div_quot[SUM_W-1]};
    assign div_ge       = div_trial >= {1'b0, acc_cnt};
    assign div_rem_nxt  = div_ge ? CNT_W'(div_trial - {1'b0, acc_cnt})
                                 : div_trial[CNT_W-1:0];
    assign div_quot_nxt = {div_quot[SUM_W-2:0], div_ge};

    // Divider datapath: load the sum on DIV entry, then one bit per cycle.
    always_ff @(posedge clk) begin
        if (end_done) begin
            div_quot <= acc_sum;
            div_rem  <= '0;
        end else if (state == DIV) begin
            div_quot <= div_quot_nxt;
            div_rem  <= div_rem_nxt;
        end
    end
`else
    assign trip_avg = '0;
`endif

    // Trip FSM: accumulate, close on trip_end, optionally divide, report.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ACC;
            end_pend  <= 1'b0;
            end_left  <= '0;
            acc_sum   <= '0;
            acc_cnt   <= '0;
            acc_rej   <= '0;
            acc_max   <= '0;
            out_valid <= 1'b0;
            trip_sum  <= '0;
            seg_cnt   <= '0;
            rej_cnt   <= '0;
            seg_max   <= '0;
            ovf       <= 1'b0;
`ifdef TRIP_AVG_EN
            trip_avg  <= '0;
            div_cnt   <= '0;
`endif
        end else begin
            if (drop) ovf <= 1'b1;
            case (state)
                ACC: begin
                    if (pop) begin
                        if (head_rej) begin
                            acc_rej <= sat_inc(acc_rej);
                        end else begin
                            acc_sum <= sat_add(acc_sum, head);
                            acc_cnt <= sat_inc(acc_cnt);
                            if (head > acc_max) acc_max <= head;
                        end
                    end
                    // Occupancy after this cycle's push/pop: a same-cycle
                    // sample still belongs to the trip being closed.
                    if (end_accept) begin
                        end_pend <= 1'b1;
                        end_left <= count_nxt;
                    end else if (end_pend && pop) begin
                        end_left <= end_left - CW'(1);
                    end
                    if (end_done) begin
`ifdef TRIP_AVG_EN
                        state   <= DIV;
                        div_cnt <= '0;
`else
                        state     <= REPORT;
                        out_valid <= 1'b1;
                        trip_sum  <= acc_sum;
                        seg_cnt   <= acc_cnt;
                        rej_cnt   <= acc_rej;
                        seg_max   <= acc_max;
`endif
                    end
                end
`ifdef TRIP_AVG_EN
                DIV: begin
                    div_cnt <= div_cnt + DCW'(1);
                    if (div_cnt == DCW'(SUM_W - 1)) begin
                        state     <= REPORT;
                        out_valid <= 1'b1;
                        trip_sum  <= acc_sum;
                        seg_cnt   <= acc_cnt;
                        rej_cnt   <= acc_rej;
                        seg_max   <= acc_max;
                        trip_avg  <= (acc_cnt == '0) ? '0 : sat_avg(div_quot_nxt);
                    end
                end
`endif
                REPORT: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        end_pend  <= 1'b0;
                        acc_sum   <= '0;
                        acc_cnt   <= '0;
                        acc_rej   <= '0;
                        acc_max   <= '0;
                        state     <= ACC;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

endmodule
